id_allocator: RTL

- Hands out unique transaction IDs from a pool of NumIds and takes them back on release.
- Tracks free IDs in a bitmap and always offers the lowest free ID, found with a trailing-zero counter.
- Offers IDs through a registered valid/ready port whose offered ID is stable, so it sits between request issue logic and a reorder/tracking table.
- Up to one allocation and one release per cycle.

---
 rtl/cf_math_pkg.sv | 13 +
 rtl/lzc.sv | 38 +++
 rtl/id_allocator.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cf_math_pkg.sv
// Shared math helpers for index and width calculations.
package cf_math_pkg;

   // Width of an index into a set of num_idx items; never less than one bit.
   function automatic int unsigned idx_width(input int unsigned num_idx);
      if (num_idx > 32'd1) begin
         return unsigned'($clog2(num_idx));
      end else begin
         return 32'd1;
      end
   endfunction

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter.
// MODE=0: cnt_o is the index of the lowest set bit (trailing zeros).
// MODE=1: cnt_o is the number of leading zeros.
// empty_o flags an all-zero input; cnt_o is then 0.
module lzc #(
   parameter int unsigned WIDTH    = 2,
   parameter int unsigned MODE     = 0,
   parameter int unsigned CntWidth = cf_math_pkg::idx_width(WIDTH)
) (
   input  logic [WIDTH-1:0]    in_i,
   output logic [CntWidth-1:0] cnt_o,
   output logic                empty_o
);

   // Priority scan; the last matching bit in scan order wins.
   always_comb begin
      int unsigned j;
      int unsigned lz;
      j     = 0;
      lz    = 0;
      cnt_o = '0;
      for (int unsigned k = 0; k < WIDTH; k++) begin
         if (MODE == 0) begin
            j = WIDTH - 1 - k;
            if (in_i[j]) cnt_o = j[CntWidth-1:0];
         end else begin
            j = k;
            if (in_i[j]) begin
               lz    = WIDTH - 1 - j;
               cnt_o = lz[CntWidth-1:0];
            end
         end
      end
   end

   assign empty_o = ~|in_i;

endmodule

// File: rtl/id_allocator.sv
// Transaction ID allocator: bitmap of free IDs, lowest free ID offered
// through a registered valid/ready port, one release per cycle.
// Optional: define ID_ALLOCATOR_RELEASE_CHECK_EN to drop and flag illegal
// releases (sticky err_o, cleared only by rst_i).
module id_allocator #(
   parameter int unsigned NumIds   = 8,
   parameter int unsigned IdWidth  = cf_math_pkg::idx_width(NumIds),
   parameter int unsigned CntWidth = $clog2(NumIds + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   output logic                alloc_valid_o,
   input  logic                alloc_ready_i,
   output logic [IdWidth-1:0]  alloc_id_o,
   input  logic                rel_valid_i,
   input  logic [IdWidth-1:0]  rel_id_i,
   output logic [CntWidth-1:0] used_cnt_o,
   output logic                full_o,
   output logic                err_o
);

   localparam logic [CntWidth-1:0] CntOne = 1;

   logic [NumIds-1:0]   free_q, free_d;
   logic [NumIds-1:0]   rel_hit, cand_mask;
   logic                off_valid_q;
   logic [IdWidth-1:0]  off_id_q;
   logic [CntWidth-1:0] used_q, used_d;
   logic [IdWidth-1:0]  cand_id;
   logic                free_empty;
   logic                slot, load, transfer, rel_ok;

   lzc #(
      .WIDTH (NumIds),
      .MODE  (0)
   ) i_lzc (
      .in_i    (free_q),
      .cnt_o   (cand_id),
      .empty_o (free_empty)
   );

   assign slot     = !off_valid_q || alloc_ready_i;
   assign load     = slot && !free_empty;
   assign transfer = off_valid_q && alloc_ready_i;

   // One-hot decode of the release ID and the candidate; out-of-range IDs decode to zero.
   always_comb begin
      rel_hit   = '0;
      cand_mask = '0;
      for (int unsigned i = 0; i < NumIds; i++) begin
         rel_hit[i]   = (rel_id_i == i[IdWidth-1:0]);
         cand_mask[i] = (cand_id == i[IdWidth-1:0]);
      end
   end

`ifdef ID_ALLOCATOR_RELEASE_CHECK_EN
   logic rel_bad;
   logic err_q;

   assign rel_bad = rel_valid_i &&
                    (!(|rel_hit) || |(rel_hit & free_q) ||
                     (off_valid_q && (rel_id_i == off_id_q)));
   assign rel_ok  = rel_valid_i && !rel_bad;

   // Sticky error flag; survives flush, cleared only by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (rel_bad) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;

`ifndef SYNTHESIS
   // Simulation-only notice of a dropped release.
   always_ff @(posedge clk_i) begin
      if (!rst_i && rel_valid_i) begin
         assert (!rel_bad)
         else $warning("id_allocator: illegal release of ID %0d dropped", rel_id_i);
      end
   end
`endif
`else
   assign rel_ok = rel_valid_i && (|rel_hit);
   assign err_o  = 1'b0;
`endif

   // Next bitmap: release sets first, load clears last so an offered ID can never be re-freed in the same cycle.
   always_comb begin
      free_d = free_q | ({NumIds{rel_ok}} & rel_hit);
      free_d = free_d & ~({NumIds{load}} & cand_mask);
   end

   // In-use counter: +1 per transfer, -1 per accepted release, floor at zero.
   always_comb begin
      used_d = used_q;
      unique case ({transfer, rel_ok && (used_q != '0)})
         2'b10:   used_d = used_q + CntOne;
         2'b01:   used_d = used_q - CntOne;
         default: used_d = used_q;
      endcase
   end

   // State registers; reset beats flush, flush beats load/transfer/release.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         free_q      <= '1;
         off_valid_q <= 1'b0;
         off_id_q    <= '0;
         used_q      <= '0;
      end else if (flush_i) begin
         free_q      <= '1;
         off_valid_q <= 1'b0;
         used_q      <= '0;
      end else begin
         free_q <= free_d;
         used_q <= used_d;
         if (slot) off_valid_q <= !free_empty;
         if (load) off_id_q    <= cand_id;
      end
   end

   assign alloc_valid_o = off_valid_q;
   assign alloc_id_o    = off_id_q;
   assign used_cnt_o    = used_q;
   assign full_o        = !off_valid_q && free_empty;

endmodule
